// File: rtl/nasti_buf_pkg.sv
// Shared constants and width helpers for the NASTI channel buffer.
package nasti_buf_pkg;

  localparam int CH_AW = 0;
  localparam int CH_W  = 1;
  localparam int CH_AR = 2;
  localparam int CH_B  = 3;
  localparam int CH_R  = 4;

  // Request payload: id, addr, len(8), size(3), burst(2), lock(1),
  // cache(4), prot(3), qos(4), region(4), user.
  function automatic int aw_w(input int id_w, input int addr_w, input int user_w);
    return id_w + addr_w + 29 + user_w;
  endfunction

  function automatic int w_w(input int data_w, input int user_w);
    return data_w + data_w / 8 + 1 + user_w;
  endfunction

  function automatic int b_w(input int id_w, input int user_w);
    return id_w + 2 + user_w;
  endfunction

  function automatic int r_w(input int id_w, input int data_w, input int user_w);
    return id_w + data_w + 3 + user_w;
  endfunction

  function automatic int cnt_w(input int depth);
    return (depth == 0) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/nasti_channel.sv
// Five-channel NASTI bundle with master/slave views.
interface nasti_channel #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/nasti_fifo.sv
// Single-channel FIFO, registered or fall-through, any depth >= 1.
module nasti_fifo
  import nasti_buf_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 2,
  parameter bit FALL_THROUGH = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(DEPTH)-1:0]   cnt
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty, ft_empty, store, deq;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    empty     = (cnt_q == '0);
    ft_empty  = FALL_THROUGH && empty;
    in_ready  = !rst && (cnt_q < CNT_W'(DEPTH));
    out_valid = !rst && (ft_empty ? in_valid : !empty);
    out_data  = ft_empty ? in_data : mem_q[rp_q];
    // A bypassed beat goes straight through and never touches storage.
    store     = in_valid && in_ready && !(ft_empty && out_ready);
    deq       = out_valid && out_ready && !empty;
    wp_d      = store ? ptr_inc(wp_q) : wp_q;
    rp_d      = deq ? ptr_inc(rp_q) : rp_q;
    cnt_d     = cnt_q;
    if (store && !deq)      cnt_d = cnt_q + CNT_W'(1);
    else if (!store && deq) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[wp_q] <= in_data;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/nasti_buf_multi.sv
// Five-channel NASTI buffer with per-channel depth/mode, occupancy and idle.
module nasti_buf_multi
  import nasti_buf_pkg::*;
#(
  parameter int         ID_WIDTH     = 1,
  parameter int         ADDR_WIDTH   = 8,
  parameter int         DATA_WIDTH   = 8,
  parameter int         USER_WIDTH   = 1,
  parameter int         AW_DEPTH     = 2,
  parameter int         W_DEPTH      = 2,
  parameter int         AR_DEPTH     = 2,
  parameter int         B_DEPTH      = 2,
  parameter int         R_DEPTH      = 2,
  parameter logic [4:0] FALL_THROUGH = 5'b00000
) (
  input  logic                        clk,
  input  logic                        rst,
  nasti_channel.slave                 s,
  nasti_channel.master                m,
  output logic [cnt_w(AW_DEPTH)-1:0]  aw_cnt,
  output logic [cnt_w(W_DEPTH)-1:0]   w_cnt,
  output logic [cnt_w(AR_DEPTH)-1:0]  ar_cnt,
  output logic [cnt_w(B_DEPTH)-1:0]   b_cnt,
  output logic [cnt_w(R_DEPTH)-1:0]   r_cnt,
  output logic                        idle
);

  localparam int AWW = aw_w(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
  localparam int WW  = w_w(DATA_WIDTH, USER_WIDTH);
  localparam int BW  = b_w(ID_WIDTH, USER_WIDTH);
  localparam int RW  = r_w(ID_WIDTH, DATA_WIDTH, USER_WIDTH);

  logic [AWW-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [WW-1:0]  w_in, w_out;
  logic [BW-1:0]  b_in, b_out;
  logic [RW-1:0]  r_in, r_out;

  assign aw_in = {s.aw_id, s.aw_addr, s.aw_len, s.aw_size, s.aw_burst, s.aw_lock,
                  s.aw_cache, s.aw_prot, s.aw_qos, s.aw_region, s.aw_user};
  assign {m.aw_id, m.aw_addr, m.aw_len, m.aw_size, m.aw_burst, m.aw_lock,
          m.aw_cache, m.aw_prot, m.aw_qos, m.aw_region, m.aw_user} = aw_out;

  assign w_in = {s.w_data, s.w_strb, s.w_last, s.w_user};
  assign {m.w_data, m.w_strb, m.w_last, m.w_user} = w_out;

  assign ar_in = {s.ar_id, s.ar_addr, s.ar_len, s.ar_size, s.ar_burst, s.ar_lock,
                  s.ar_cache, s.ar_prot, s.ar_qos, s.ar_region, s.ar_user};
  assign {m.ar_id, m.ar_addr, m.ar_len, m.ar_size, m.ar_burst, m.ar_lock,
          m.ar_cache, m.ar_prot, m.ar_qos, m.ar_region, m.ar_user} = ar_out;

  // Response channels flow m -> s.
  assign b_in = {m.b_id, m.b_resp, m.b_user};
  assign {s.b_id, s.b_resp, s.b_user} = b_out;

  assign r_in = {m.r_id, m.r_data, m.r_resp, m.r_last, m.r_user};
  assign {s.r_id, s.r_data, s.r_resp, s.r_last, s.r_user} = r_out;

  if (AW_DEPTH == 0) begin : g_aw_wire
    assign aw_out     = aw_in;
    assign m.aw_valid = s.aw_valid;
    assign s.aw_ready = m.aw_ready;
    assign aw_cnt     = '0;
  end else begin : g_aw_fifo
    nasti_fifo #(.WIDTH(AWW), .DEPTH(AW_DEPTH), .FALL_THROUGH(FALL_THROUGH[CH_AW])) u_fifo (
      .clk(clk), .rst(rst),
      .in_valid(s.aw_valid), .in_ready(s.aw_ready), .in_data(aw_in),
      .out_valid(m.aw_valid), .out_ready(m.aw_ready), .out_data(aw_out),
      .cnt(aw_cnt)
    );
  end

  if (W_DEPTH == 0) begin : g_w_wire
    assign w_out     = w_in;
    assign m.w_valid = s.w_valid;
    assign s.w_ready = m.w_ready;
    assign w_cnt     = '0;
  end else begin : g_w_fifo
    nasti_fifo #(.WIDTH(WW), .DEPTH(W_DEPTH), .FALL_THROUGH(FALL_THROUGH[CH_W])) u_fifo (
      .clk(clk), .rst(rst),
      .in_valid(s.w_valid), .in_ready(s.w_ready), .in_data(w_in),
      .out_valid(m.w_valid), .out_ready(m.w_ready), .out_data(w_out),
      .cnt(w_cnt)
    );
  end

  if (AR_DEPTH == 0) begin : g_ar_wire
    assign ar_out     = ar_in;
    assign m.ar_valid = s.ar_valid;
    assign s.ar_ready = m.ar_ready;
    assign ar_cnt     = '0;
  end else begin : g_ar_fifo
    nasti_fifo #(.WIDTH(AWW), .DEPTH(AR_DEPTH), .FALL_THROUGH(FALL_THROUGH[CH_AR])) u_fifo (
      .clk(clk), .rst(rst),
      .in_valid(s.ar_valid), .in_ready(s.ar_ready), .in_data(ar_in),
      .out_valid(m.ar_valid), .out_ready(m.ar_ready), .out_data(ar_out),
      .cnt(ar_cnt)
    );
  end

  if (B_DEPTH == 0) begin : g_b_wire
    assign b_out     = b_in;
    assign s.b_valid = m.b_valid;
    assign m.b_ready = s.b_ready;
    assign b_cnt     = '0;
  end else begin : g_b_fifo
    nasti_fifo #(.WIDTH(BW), .DEPTH(B_DEPTH), .FALL_THROUGH(FALL_THROUGH[CH_B])) u_fifo (
      .clk(clk), .rst(rst),
      .in_valid(m.b_valid), .in_ready(m.b_ready), .in_data(b_in),
      .out_valid(s.b_valid), .out_ready(s.b_ready), .out_data(b_out),
      .cnt(b_cnt)
    );
  end

  if (R_DEPTH == 0) begin : g_r_wire
    assign r_out     = r_in;
    assign s.r_valid = m.r_valid;
    assign m.r_ready = s.r_ready;
    assign r_cnt     = '0;
  end else begin : g_r_fifo
    nasti_fifo #(.WIDTH(RW), .DEPTH(R_DEPTH), .FALL_THROUGH(FALL_THROUGH[CH_R])) u_fifo (
      .clk(clk), .rst(rst),
      .in_valid(m.r_valid), .in_ready(m.r_ready), .in_data(r_in),
      .out_valid(s.r_valid), .out_ready(s.r_ready), .out_data(r_out),
      .cnt(r_cnt)
    );
  end

  // Held low during reset so power gating never engages mid-reset.
  assign idle = !rst
    && (aw_cnt == '0) && (w_cnt == '0) && (ar_cnt == '0) && (b_cnt == '0) && (r_cnt == '0)
    && !(s.aw_valid || s.w_valid || s.ar_valid || s.b_valid || s.r_valid)
    && !(m.aw_valid || m.w_valid || m.ar_valid || m.b_valid || m.r_valid);

endmodule

// File: tb/tb_nasti_buf_multi.sv
// Directed bench: AW depth 3, W/AR depth 2, B wire, R fall-through depth 2.
module tb_nasti_buf_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] aw_cnt, w_cnt, ar_cnt, r_cnt;
  logic       b_cnt;
  logic       idle;
  int         checks   = 0;
  int         failures = 0;

  nasti_channel #(.ID_WIDTH(1), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1)) s_if ();
  nasti_channel #(.ID_WIDTH(1), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1)) m_if ();

  nasti_buf_multi #(
    .ID_WIDTH(1), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1),
    .AW_DEPTH(3), .W_DEPTH(2), .AR_DEPTH(2), .B_DEPTH(0), .R_DEPTH(2),
    .FALL_THROUGH(5'b10000)
  ) dut (
    .clk(clk), .rst(rst), .s(s_if), .m(m_if),
    .aw_cnt(aw_cnt), .w_cnt(w_cnt), .ar_cnt(ar_cnt), .b_cnt(b_cnt), .r_cnt(r_cnt),
    .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s_if.aw_id = '0; s_if.aw_addr = '0; s_if.aw_len = '0; s_if.aw_size = '0;
    s_if.aw_burst = '0; s_if.aw_lock = '0; s_if.aw_cache = '0; s_if.aw_prot = '0;
    s_if.aw_qos = '0; s_if.aw_region = '0; s_if.aw_user = '0; s_if.aw_valid = 1'b0;
    s_if.w_data = '0; s_if.w_strb = '0; s_if.w_last = 1'b0; s_if.w_user = '0; s_if.w_valid = 1'b0;
    s_if.ar_id = '0; s_if.ar_addr = '0; s_if.ar_len = '0; s_if.ar_size = '0;
    s_if.ar_burst = '0; s_if.ar_lock = '0; s_if.ar_cache = '0; s_if.ar_prot = '0;
    s_if.ar_qos = '0; s_if.ar_region = '0; s_if.ar_user = '0; s_if.ar_valid = 1'b0;
    s_if.b_ready = 1'b0; s_if.r_ready = 1'b0;
    m_if.aw_ready = 1'b0; m_if.w_ready = 1'b0; m_if.ar_ready = 1'b0;
    m_if.b_id = '0; m_if.b_resp = '0; m_if.b_user = '0; m_if.b_valid = 1'b0;
    m_if.r_id = '0; m_if.r_data = '0; m_if.r_resp = '0; m_if.r_last = 1'b0;
    m_if.r_user = '0; m_if.r_valid = 1'b0;

    // Reset
    cyc(); cyc();
    chk("rst_aw_ready", s_if.aw_ready, 1'b0);
    chk("rst_r_valid", s_if.r_valid, 1'b0);
    chk("rst_idle", idle, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_aw_ready", s_if.aw_ready, 1'b1);
    chk("post_rst_w_ready", s_if.w_ready, 1'b1);
    chk("post_rst_ar_ready", s_if.ar_ready, 1'b1);
    chk("post_rst_m_aw_valid", m_if.aw_valid, 1'b0);
    chk("post_rst_m_w_valid", m_if.w_valid, 1'b0);
    chk("post_rst_s_r_valid", s_if.r_valid, 1'b0);
    chk("post_rst_idle", idle, 1'b1);
    chk("post_rst_aw_cnt", aw_cnt, 2'd0);

    // AW depth 3, fill with m.aw_ready low
    s_if.aw_valid = 1'b1; s_if.aw_addr = 8'h10; s_if.aw_id = 1'b1;
    #1;
    chk("aw_push0_ready", s_if.aw_ready, 1'b1);
    chk("aw_reg_no_bypass", m_if.aw_valid, 1'b0);
    cyc();
    s_if.aw_addr = 8'h20; s_if.aw_id = 1'b0;
    #1;
    chk("aw_lat1_valid", m_if.aw_valid, 1'b1);
    chk("aw_lat1_addr", m_if.aw_addr, 8'h10);
    chk("aw_lat1_id", m_if.aw_id, 1'b1);
    cyc();
    s_if.aw_addr = 8'h30;
    cyc();
    s_if.aw_addr = 8'h40;
    #1;
    chk("aw_full_cnt", aw_cnt, 2'd3);
    chk("aw_full_ready", s_if.aw_ready, 1'b0);
    chk("aw_full_idle", idle, 1'b0);
    s_if.aw_valid = 1'b0;
    m_if.aw_ready = 1'b1;
    #1;
    chk("aw_drain0", m_if.aw_addr, 8'h10);
    chk("aw_full_pop_ready", s_if.aw_ready, 1'b0);
    cyc();
    chk("aw_drain1", m_if.aw_addr, 8'h20);
    chk("aw_drain1_ready", s_if.aw_ready, 1'b1);
    cyc();
    chk("aw_drain2", m_if.aw_addr, 8'h30);
    chk("aw_drain2_valid", m_if.aw_valid, 1'b1);
    cyc();
    chk("aw_empty_valid", m_if.aw_valid, 1'b0);
    chk("aw_empty_cnt", aw_cnt, 2'd0);
    // Both pointers have wrapped to 0; a new beat must come out intact
    m_if.aw_ready = 1'b0;
    s_if.aw_valid = 1'b1; s_if.aw_addr = 8'h50;
    cyc();
    s_if.aw_valid = 1'b0;
    #1;
    chk("aw_wrap_addr", m_if.aw_addr, 8'h50);
    chk("aw_wrap_cnt", aw_cnt, 2'd1);
    m_if.aw_ready = 1'b1;
    cyc();
    chk("aw_wrap_drained", aw_cnt, 2'd0);
    m_if.aw_ready = 1'b0;

    // W depth 2: full, stall, then sustained push+pop
    s_if.w_valid = 1'b1; s_if.w_strb = 1'b1; s_if.w_data = 8'hA1;
    cyc();
    s_if.w_data = 8'hA2;
    cyc();
    s_if.w_data = 8'hA3; s_if.w_last = 1'b1;
    #1;
    chk("w_full_cnt", w_cnt, 2'd2);
    chk("w_full_ready", s_if.w_ready, 1'b0);
    m_if.w_ready = 1'b1;
    #1;
    chk("w_stall_ready", s_if.w_ready, 1'b0);
    chk("w_pop0_data", m_if.w_data, 8'hA1);
    cyc();
    chk("w_resume_ready", s_if.w_ready, 1'b1);
    chk("w_pop1_data", m_if.w_data, 8'hA2);
    chk("w_pop1_cnt", w_cnt, 2'd1);
    cyc();
    s_if.w_data = 8'hA4; s_if.w_last = 1'b0;
    #1;
    chk("w_pushpop_cnt", w_cnt, 2'd1);
    chk("w_pop2_data", m_if.w_data, 8'hA3);
    chk("w_pop2_last", m_if.w_last, 1'b1);
    chk("w_pushpop_ready", s_if.w_ready, 1'b1);
    cyc();
    s_if.w_valid = 1'b0;
    #1;
    chk("w_pop3_data", m_if.w_data, 8'hA4);
    chk("w_pop3_last", m_if.w_last, 1'b0);
    chk("w_pop3_cnt", w_cnt, 2'd1);
    cyc();
    chk("w_empty_valid", m_if.w_valid, 1'b0);
    chk("w_empty_cnt", w_cnt, 2'd0);
    m_if.w_ready = 1'b0;

    // R fall-through
    s_if.r_ready = 1'b1;
    m_if.r_valid = 1'b1; m_if.r_data = 8'hAB; m_if.r_id = 1'b1; m_if.r_last = 1'b1;
    #1;
    chk("r_ft_valid", s_if.r_valid, 1'b1);
    chk("r_ft_data", s_if.r_data, 8'hAB);
    chk("r_ft_id", s_if.r_id, 1'b1);
    chk("r_ft_m_ready", m_if.r_ready, 1'b1);
    chk("r_ft_cnt_same", r_cnt, 2'd0);
    cyc();
    chk("r_ft_cnt_after", r_cnt, 2'd0);
    s_if.r_ready = 1'b0; m_if.r_data = 8'hCD; m_if.r_last = 1'b0;
    #1;
    chk("r_ft_stall_data", s_if.r_data, 8'hCD);
    cyc();
    m_if.r_valid = 1'b0; m_if.r_data = 8'h00;
    #1;
    chk("r_stored_cnt", r_cnt, 2'd1);
    chk("r_stored_valid", s_if.r_valid, 1'b1);
    chk("r_stored_data", s_if.r_data, 8'hCD);
    s_if.r_ready = 1'b1;
    cyc();
    chk("r_drained_cnt", r_cnt, 2'd0);
    chk("r_drained_valid", s_if.r_valid, 1'b0);
    s_if.r_ready = 1'b0;

    // B pass-through
    m_if.b_valid = 1'b1; m_if.b_id = 1'b1; m_if.b_resp = 2'b10;
    #1;
    chk("b_wire_valid", s_if.b_valid, 1'b1);
    chk("b_wire_resp", s_if.b_resp, 2'b10);
    chk("b_wire_id", s_if.b_id, 1'b1);
    chk("b_wire_ready0", m_if.b_ready, 1'b0);
    chk("b_wire_cnt", b_cnt, 1'b0);
    s_if.b_ready = 1'b1; m_if.b_resp = 2'b01;
    #1;
    chk("b_wire_ready1", m_if.b_ready, 1'b1);
    chk("b_wire_resp2", s_if.b_resp, 2'b01);
    cyc();
    m_if.b_valid = 1'b0; s_if.b_ready = 1'b0;
    #1;
    chk("b_wire_valid0", s_if.b_valid, 1'b0);
    chk("b_wire_ready_low", m_if.b_ready, 1'b0);

    // AR: reset with two beats buffered
    s_if.ar_valid = 1'b1; s_if.ar_addr = 8'h11;
    cyc();
    s_if.ar_addr = 8'h22;
    cyc();
    s_if.ar_valid = 1'b0;
    #1;
    chk("ar_buffered_cnt", ar_cnt, 2'd2);
    chk("ar_buffered_head", m_if.ar_addr, 8'h11);
    rst = 1'b1;
    #1;
    chk("ar_rst_valid", m_if.ar_valid, 1'b0);
    chk("ar_rst_ready", s_if.ar_ready, 1'b0);
    chk("ar_rst_idle", idle, 1'b0);
    cyc();
    rst = 1'b0;
    #1;
    chk("ar_post_rst_cnt", ar_cnt, 2'd0);
    chk("ar_post_rst_valid", m_if.ar_valid, 1'b0);
    m_if.ar_ready = 1'b1;
    cyc();
    chk("ar_no_stale_valid", m_if.ar_valid, 1'b0);
    chk("ar_no_stale_cnt", ar_cnt, 2'd0);
    chk("final_idle", idle, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
